// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master.
package apb_cmd_pkg;

  // Command sequencing states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WGAP = 3'd2,
    RD   = 3'd3,
    RGAP = 3'd4,
    RSP  = 3'd5
  } state_t;

  // One-hot target selects on MSELx.
  localparam logic [3:0] SEL_FRAC_DECI = 4'b0001;
  localparam logic [3:0] SEL_IIR       = 4'b0010;
  localparam logic [3:0] SEL_CTRL      = 4'b0100;
  localparam logic [3:0] SEL_CIC       = 4'b1000;

  // Cycles MTRANS is held per transaction (SETUP + ACCESS + PREADY).
  localparam int unsigned HOLD_CYC_DEFAULT = 3;

  // Width of the saturating error counter.
  localparam int unsigned ERR_CNT_WIDTH = 8;

endpackage

// File: rtl/apb_cmd_master.sv
// Host-side APB initiator: one command at a time, fixed-length bus
// transactions, optional write-then-readback verify.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 32,
  parameter int unsigned COEFF_WIDTH = 20,
  parameter int unsigned COMP        = 4,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic                          cmd_verify,
  input  logic [COMP-1:0]               cmd_sel,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic signed [COEFF_WIDTH-1:0] cmd_wdata,
  output logic                          MTRANS,
  output logic                          MWRITE,
  output logic [COMP-1:0]               MSELx,
  output logic [ADDR_WIDTH-1:0]         MADDR,
  output logic signed [COEFF_WIDTH-1:0] MWDATA,
  input  logic [PDATA_WIDTH-1:0]        MRDATA,
  output logic                          rsp_valid,
  output logic [PDATA_WIDTH-1:0]        rsp_rdata,
  output logic                          rsp_err,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt,
  output logic                          busy
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  state_t state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Latched command copy; live cmd_* inputs are ignored while busy.
  logic                          verify_q;
  logic [COMP-1:0]               sel_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic signed [COEFF_WIDTH-1:0] wdata_q;
  logic [PDATA_WIDTH-1:0]        rdata_q;
  logic                          err_q;

  // Decoded next-cycle output values.
  logic                          accept_c;
  logic                          sel_onehot_c;
  logic                          verify_mismatch_c;
  logic                          mtrans_c;
  logic                          mwrite_c;
  logic [COMP-1:0]               msel_c;
  logic [ADDR_WIDTH-1:0]         maddr_c;
  logic signed [COEFF_WIDTH-1:0] mwdata_c;
  logic                          rsp_valid_c;
  logic [PDATA_WIDTH-1:0]        rsp_rdata_c;
  logic                          rsp_err_c;

  // Handshake, select legality and readback compare.
  always_comb begin
    accept_c          = cmd_valid && cmd_ready;
    sel_onehot_c      = (cmd_sel != '0) && ((cmd_sel & (cmd_sel - COMP'(1))) == '0);
    verify_mismatch_c = (MRDATA[COEFF_WIDTH-1:0] != $unsigned(wdata_q)) ||
                        (MRDATA[PDATA_WIDTH-1:COEFF_WIDTH] != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, hold counter and output decode.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    mtrans_c    = 1'b0;
    mwrite_c    = 1'b0;
    msel_c      = '0;
    maddr_c     = '0;
    mwdata_c    = '0;
    rsp_valid_c = 1'b0;
    rsp_rdata_c = '0;
    rsp_err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (accept_c) begin
          if (!sel_onehot_c) begin
            state_d = RSP;
          end else if (cmd_write) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        mtrans_c = 1'b1;
        mwrite_c = 1'b1;
        msel_c   = sel_q;
        maddr_c  = addr_q;
        mwdata_c = wdata_q;
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = WGAP;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      WGAP: begin
        state_d = verify_q ? RD : RSP;
      end
      RD: begin
        mtrans_c = 1'b1;
        msel_c   = sel_q;
        maddr_c  = addr_q;
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = RGAP;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RGAP: begin
        state_d = RSP;
      end
      RSP: begin
        rsp_valid_c = 1'b1;
        rsp_rdata_c = rdata_q;
        rsp_err_c   = err_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command latch, read capture and registered outputs.
  // RGAP is the last cycle the registered MTRANS is high, so read data
  // is captured there.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      verify_q  <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      MTRANS    <= 1'b0;
      MWRITE    <= 1'b0;
      MSELx     <= '0;
      MADDR     <= '0;
      MWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      if (accept_c) begin
        verify_q <= cmd_write && cmd_verify;
        sel_q    <= cmd_sel;
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        rdata_q  <= '0;
        err_q    <= !sel_onehot_c;
      end else if (state_q == RGAP) begin
        rdata_q <= MRDATA;
        if (verify_q) begin
          err_q <= verify_mismatch_c;
        end
      end
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      MTRANS    <= mtrans_c;
      MWRITE    <= mwrite_c;
      MSELx     <= msel_c;
      MADDR     <= maddr_c;
      MWDATA    <= mwdata_c;
      rsp_valid <= rsp_valid_c;
      rsp_rdata <= rsp_rdata_c;
      rsp_err   <= rsp_err_c;
    end
  end

  // Saturating count of error responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (rsp_valid_c && rsp_err_c && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized self-checking bench for apb_cmd_master.
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;

  localparam int unsigned H = 3;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic               cmd_verify;
  logic [3:0]         cmd_sel;
  logic [6:0]         cmd_addr;
  logic signed [19:0] cmd_wdata;
  logic               MTRANS;
  logic               MWRITE;
  logic [3:0]         MSELx;
  logic [6:0]         MADDR;
  logic signed [19:0] MWDATA;
  logic [31:0]        MRDATA;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic [7:0]         err_cnt;
  logic               busy;

  int total;
  int bad;
  int exp_errs;

  apb_cmd_master #(
    .ADDR_WIDTH(7), .PDATA_WIDTH(32), .COEFF_WIDTH(20), .COMP(4), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_verify(cmd_verify), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx), .MADDR(MADDR),
    .MWDATA(MWDATA), .MRDATA(MRDATA),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_cnt(err_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what a command should look like from the outside.
  typedef struct {
    int          lat;
    int          wr_cyc;
    int          rd_cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  function automatic exp_t model(input bit wr, input bit vf, input logic [3:0] sel,
                                 input logic [19:0] wd, input logic [31:0] mrd);
    exp_t e;
    bit legal;
    bit does_read;
    legal     = ($countones(sel) == 1);
    does_read = legal && (!wr || vf);
    e.wr_cyc  = (legal && wr) ? H : 0;
    e.rd_cyc  = does_read ? H : 0;
    e.rdata   = does_read ? mrd : 32'd0;
    e.err     = !legal || (wr && vf && (mrd != {12'd0, wd}));
    if (!legal)         e.lat = 2;
    else if (wr && vf)  e.lat = 2 * (H + 1) + 2;
    else                e.lat = H + 3;
    return e;
  endfunction

  // Observed behaviour of one command.
  typedef struct {
    int          lat;
    int          wr_cyc;
    int          rd_cyc;
    int          fld_bad;
    int          gap_bad;
    int          ready_bad;
    int          pulse_bad;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  ecnt;
  } obs_t;

  // Issue one command (entered and left just after a negedge) and watch the bus.
  task automatic do_cmd(input bit wr, input bit vf, input logic [3:0] sel,
                        input logic [6:0] addr, input logic [19:0] wd,
                        input logic [31:0] mrd, output obs_t o);
    int n;
    o = '{default: 0};
    MRDATA     = mrd;
    cmd_write  = wr;
    cmd_verify = vf;
    cmd_sel    = sel;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_write  = 1'($urandom);
    cmd_verify = 1'($urandom);
    cmd_sel    = 4'($urandom);
    cmd_addr   = 7'($urandom);
    cmd_wdata  = 20'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid) begin
        o.lat   = k;
        o.rdata = rsp_rdata;
        o.err   = rsp_err;
        break;
      end
      if (cmd_ready) o.ready_bad++;
      if (MTRANS) begin
        if (MWRITE) begin
          o.wr_cyc++;
          if (MWDATA != wd) o.fld_bad++;
          if (o.rd_cyc > 0) o.fld_bad++;
        end else begin
          o.rd_cyc++;
          if (MWDATA != 20'd0) o.fld_bad++;
        end
        if (MSELx != sel || MADDR != addr) o.fld_bad++;
      end else if (MSELx != 4'd0 || MWDATA != 20'd0 || MWRITE) begin
        o.gap_bad++;
      end
      @(negedge clk);
    end
    @(negedge clk);
    o.pulse_bad = rsp_valid ? 1 : 0;
    o.ecnt      = err_cnt;
  endtask

  task automatic test_reset;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_verify = 1'b0;
    cmd_sel = SEL_IIR; cmd_addr = 7'd5; cmd_wdata = 20'd9; MRDATA = 32'd0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (MTRANS !== 1'b0 || MWRITE !== 1'b0 || MSELx !== 4'd0 || MADDR !== 7'd0 ||
        MWDATA !== 20'd0) begin
      bad++; $display("FAIL reset_bus: got trans=%b write=%b sel=%h addr=%h wdata=%h want all 0",
                      MTRANS, MWRITE, MSELx, MADDR, MWDATA);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || err_cnt !== 8'd0 ||
        busy !== 1'b0) begin
      bad++; $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b cnt=%0d busy=%b want all 0",
                      rsp_valid, rsp_rdata, rsp_err, err_cnt, busy);
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    exp_errs = 0;
    @(negedge clk);
  endtask

  task automatic test_write;
    obs_t o;
    exp_t e;
    e = model(1'b1, 1'b0, SEL_FRAC_DECI, 20'h7FFFF, 32'hDEADBEEF);
    do_cmd(1'b1, 1'b0, SEL_FRAC_DECI, 7'd10, 20'h7FFFF, 32'hDEADBEEF, o);
    total++; if (o.lat != 6) begin bad++; $display("FAIL write_latency: got %0d want 6", o.lat); end
    total++; if (o.wr_cyc != e.wr_cyc || o.rd_cyc != e.rd_cyc) begin
      bad++; $display("FAIL write_mtrans: got wr=%0d rd=%0d want wr=%0d rd=%0d",
                      o.wr_cyc, o.rd_cyc, e.wr_cyc, e.rd_cyc); end
    total++; if (o.fld_bad != 0 || o.gap_bad != 0) begin
      bad++; $display("FAIL write_fields: got bad=%0d gap=%0d want 0 0", o.fld_bad, o.gap_bad); end
    total++; if (o.rdata !== 32'd0 || o.err !== 1'b0) begin
      bad++; $display("FAIL write_rsp: got rdata=%h err=%b want 0 0", o.rdata, o.err); end
    total++; if (o.ready_bad != 0 || o.pulse_bad != 0) begin
      bad++; $display("FAIL write_handshake: got ready_busy=%0d pulse=%0d want 0 0",
                      o.ready_bad, o.pulse_bad); end
  endtask

  task automatic test_verify;
    obs_t o;
    do_cmd(1'b1, 1'b1, SEL_IIR, 7'd3, -20'sd5, 32'h000FFFFB, o);
    total++; if (o.lat != 10 || o.wr_cyc != 3 || o.rd_cyc != 3) begin
      bad++; $display("FAIL verify_ok_shape: got lat=%0d wr=%0d rd=%0d want 10 3 3",
                      o.lat, o.wr_cyc, o.rd_cyc); end
    total++; if (o.fld_bad != 0 || o.gap_bad != 0) begin
      bad++; $display("FAIL verify_ok_fields: got bad=%0d gap=%0d want 0 0", o.fld_bad, o.gap_bad); end
    total++; if (o.err !== 1'b0 || o.rdata !== 32'h000FFFFB) begin
      bad++; $display("FAIL verify_ok_rsp: got err=%b rdata=%h want 0 000ffffb", o.err, o.rdata); end
    do_cmd(1'b1, 1'b1, SEL_IIR, 7'd3, -20'sd5, 32'h000FFFFA, o);
    exp_errs++;
    total++; if (o.err !== 1'b1) begin bad++; $display("FAIL verify_bad_err: got %b want 1", o.err); end
    total++; if (o.ecnt !== 8'd1) begin bad++; $display("FAIL verify_bad_cnt: got %0d want 1", o.ecnt); end
  endtask

  task automatic test_read;
    obs_t o;
    do_cmd(1'b0, 1'b0, SEL_CIC, 7'd0, 20'h12345, 32'h0000000C, o);
    total++; if (o.lat != H + 3) begin bad++; $display("FAIL read_latency: got %0d want %0d", o.lat, H + 3); end
    total++; if (o.rdata !== 32'hC || o.err !== 1'b0) begin
      bad++; $display("FAIL read_rsp: got rdata=%h err=%b want c 0", o.rdata, o.err); end
    total++; if (o.wr_cyc != 0 || o.rd_cyc != 3 || o.fld_bad != 0) begin
      bad++; $display("FAIL read_bus: got wr=%0d rd=%0d bad=%0d want 0 3 0",
                      o.wr_cyc, o.rd_cyc, o.fld_bad); end
  endtask

  task automatic test_bad_sel;
    obs_t o;
    do_cmd(1'b1, 1'b0, 4'b0011, 7'd8, 20'd1, 32'd0, o);
    exp_errs++;
    total++; if (o.lat != 2 || o.wr_cyc != 0 || o.rd_cyc != 0) begin
      bad++; $display("FAIL bad_sel_shape: got lat=%0d wr=%0d rd=%0d want 2 0 0",
                      o.lat, o.wr_cyc, o.rd_cyc); end
    total++; if (o.err !== 1'b1 || o.ecnt !== 8'(exp_errs)) begin
      bad++; $display("FAIL bad_sel_err: got err=%b cnt=%0d want 1 %0d", o.err, o.ecnt, exp_errs); end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t e;
    bit wr, vf;
    logic [3:0] sel;
    logic [19:0] wd;
    logic [31:0] mrd;
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      vf  = 1'($urandom);
      sel = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      wd  = 20'($urandom);
      case ($urandom_range(0, 2))
        0:       mrd = {12'd0, wd};
        1:       mrd = {12'($urandom_range(1, 4095)), wd};
        default: mrd = $urandom;
      endcase
      e = model(wr, vf, sel, wd, mrd);
      do_cmd(wr, vf, sel, 7'($urandom), wd, mrd, o);
      if (e.err && exp_errs < 255) exp_errs++;
      total++;
      if (o.lat != e.lat || o.wr_cyc != e.wr_cyc || o.rd_cyc != e.rd_cyc) begin
        bad++; $display("FAIL rand_shape[%0d]: got lat=%0d wr=%0d rd=%0d want %0d %0d %0d",
                        i, o.lat, o.wr_cyc, o.rd_cyc, e.lat, e.wr_cyc, e.rd_cyc); end
      total++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.ecnt !== 8'(exp_errs)) begin
        bad++; $display("FAIL rand_rsp[%0d]: got rdata=%h err=%b cnt=%0d want %h %b %0d",
                        i, o.rdata, o.err, o.ecnt, e.rdata, e.err, exp_errs); end
      total++;
      if (o.fld_bad != 0 || o.gap_bad != 0 || o.ready_bad != 0 || o.pulse_bad != 0) begin
        bad++; $display("FAIL rand_bus[%0d]: got fld=%0d gap=%0d ready=%0d pulse=%0d want all 0",
                        i, o.fld_bad, o.gap_bad, o.ready_bad, o.pulse_bad); end
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    cmd_write = 1'b1; cmd_verify = 1'b1; cmd_sel = SEL_CTRL;
    cmd_addr = 7'd20; cmd_wdata = 20'd77; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (MTRANS !== 1'b1) begin bad++; $display("FAIL mid_started: got %b want 1", MTRANS); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_errs = 0;
    total++;
    if (MTRANS !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_reset: got trans=%b busy=%b ready=%b cnt=%0d want 0 0 1 0",
                      MTRANS, busy, cmd_ready, err_cnt); end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || MTRANS) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL mid_no_rsp: got %0d stray cycles want 0", stray); end
  endtask

  task automatic test_err_sat;
    obs_t o;
    logic [3:0] sel;
    int wrong;
    wrong = 0;
    for (int i = 0; i < 300; i++) begin
      do sel = 4'($urandom); while ($countones(sel) == 1);
      do_cmd(1'($urandom), 1'($urandom), sel, 7'($urandom), 20'($urandom), $urandom, o);
      if (exp_errs < 255) exp_errs++;
      if (o.err !== 1'b1 || o.ecnt !== 8'(exp_errs)) wrong++;
    end
    total++; if (wrong != 0) begin bad++; $display("FAIL sat_track: got %0d wrong responses want 0", wrong); end
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_final: got %0d want 255", err_cnt); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_errs = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_verify = 1'b0;
    cmd_sel = '0;
    cmd_addr = '0;
    cmd_wdata = '0;
    MRDATA = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_verify();
    test_read();
    test_bad_sel();
    test_random();
    test_reset_mid();
    test_err_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
